// File: rtl/factorial_job_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// factorial_job_sequencer_pkg
//   Shared definitions for the factorial job sequencer:
//     - FSM state encoding (3-bit enum)
//     - FACT_MAX_N_64B: largest N whose factorial fits in 64 bits
//     - RESULT_W / N_W: result and request widths
//     - small_fact(): locally computed result for the N <= 2 bypass path
// ---------------------------------------------------------------------------
package factorial_job_sequencer_pkg;

  localparam int FACT_MAX_N_64B = 20;
  localparam int RESULT_W       = 64;
  localparam int N_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_BYPASS  = 3'd2,
    ST_RUN     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_ABORT   = 3'd5,
    ST_GAP     = 3'd6,
    ST_OUT     = 3'd7
  } seq_state_t;

  // 0! = 1! = 1, 2! = 2; only called for N <= 2
  function automatic logic [RESULT_W-1:0] small_fact(input logic [N_W-1:0] n);
    return (n == 32'd2) ? 64'd2 : 64'd1;
  endfunction

endpackage

// File: rtl/factorial_job_sequencer_fact_req_fifo.sv
// ---------------------------------------------------------------------------
// fact_req_fifo
//   Request queue for the factorial job sequencer. Power-of-two depth,
//   pointers wrap naturally modulo DEPTH.
// Ports:
//   clk_32b     in   clock
//   resetn_32b  in   asynchronous active-low reset (queue emptied)
//   push        in   write push_data (ignored when full)
//   push_data   in   WIDTH  entry to enqueue
//   pop         in   drop the head entry (ignored when empty)
//   head        out  WIDTH  current head entry
//   full        out  queue full (from registered count)
//   empty       out  queue empty
//   count       out  number of stored entries
// ---------------------------------------------------------------------------
module fact_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_32b,
  input  logic                     resetn_32b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // full comes from the registered count, so a pop does not open a slot
  // for a push in the same cycle
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_32b) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_32b or negedge resetn_32b) begin
    if (!resetn_32b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/factorial_job_sequencer.sv
// ---------------------------------------------------------------------------
// factorial_job_sequencer
//   Upstream controller for the LUT factorial engine. Queues N requests,
//   runs them one at a time through the engine (or locally for N <= 2),
//   and presents each 64-bit result on a valid/ready port. eng_start is
//   always low for at least one cycle between jobs so the engine re-arms.
// Optional feature:
//   FACT_SEQ_OVERFLOW_GUARD_EN  when defined, N > 20 is aborted in LOAD
//                               (res_error=1, res_factorial=0) without
//                               starting the engine; otherwise N > 20 goes
//                               to the engine and the result wraps mod 2^64.
// Parameters:
//   FIFO_DEPTH      request queue entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  cycles allowed in RUN before the job is aborted
// Ports:
//   clk_32b, resetn_32b            clock, async active-low reset
//   req_valid/req_n/req_ready      request in (32-bit N)
//   eng_source_number/eng_start    to engine
//   eng_factorial/eng_output_ready from engine
//   res_valid/res_n/res_factorial/res_error/res_ready  result out
//   busy                           job in flight or queue non-empty
// ---------------------------------------------------------------------------
module factorial_job_sequencer
  import factorial_job_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_32b,
  input  logic                resetn_32b,
  input  logic                req_valid,
  input  logic [N_W-1:0]      req_n,
  output logic                req_ready,
  output logic [N_W-1:0]      eng_source_number,
  output logic                eng_start,
  input  logic [RESULT_W-1:0] eng_factorial,
  input  logic                eng_output_ready,
  output logic                res_valid,
  output logic [N_W-1:0]      res_n,
  output logic [RESULT_W-1:0] res_factorial,
  output logic                res_error,
  input  logic                res_ready,
  output logic                busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t                   state;
  logic [N_W-1:0]               job_n;
  logic [TW-1:0]                timeout_cnt;
  logic                         alive;
  logic [N_W-1:0]               fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_push;
  logic                         fifo_pop;

  // req_ready stays low through reset and rises the first clock after release
  always_ff @(posedge clk_32b or negedge resetn_32b) begin
    if (!resetn_32b) alive <= 1'b0;
    else             alive <= 1'b1;
  end

  assign req_ready = alive && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_pop  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  fact_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (N_W)
  ) u_fifo (
    .clk_32b    (clk_32b),
    .resetn_32b (resetn_32b),
    .push       (fifo_push),
    .push_data  (req_n),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Job FSM. All engine and result outputs are registered here; result
  // registers are only written on the way out of BYPASS/CAPTURE/ABORT so
  // they stay stable while a result waits for res_ready.
  always_ff @(posedge clk_32b or negedge resetn_32b) begin
    if (!resetn_32b) begin
      state             <= ST_IDLE;
      job_n             <= '0;
      timeout_cnt       <= '0;
      eng_source_number <= '0;
      eng_start         <= 1'b0;
      res_valid         <= 1'b0;
      res_n             <= '0;
      res_factorial     <= '0;
      res_error         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && !res_valid) state <= ST_LOAD;
        end
        ST_LOAD: begin
          job_n             <= fifo_head;
          eng_source_number <= fifo_head;
          timeout_cnt       <= '0;
          if (fifo_head <= 32'd2) begin
            state <= ST_BYPASS;
`ifdef FACT_SEQ_OVERFLOW_GUARD_EN
          end else if (fifo_head > 32'(FACT_MAX_N_64B)) begin
            state <= ST_ABORT;
`endif
          end else begin
            state     <= ST_RUN;
            eng_start <= 1'b1;
          end
        end
        ST_BYPASS: begin
          res_n         <= job_n;
          res_factorial <= small_fact(job_n);
          res_error     <= 1'b0;
          res_valid     <= 1'b1;
          state         <= ST_OUT;
        end
        ST_RUN: begin
          // the engine's final add lands one cycle after output_ready,
          // so the result is sampled in CAPTURE rather than here
          if (eng_output_ready) begin
            state <= ST_CAPTURE;
          end else if (timeout_cnt == TO_LAST) begin
            state     <= ST_ABORT;
            eng_start <= 1'b0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          res_n         <= job_n;
          res_factorial <= eng_factorial;
          res_error     <= 1'b0;
          eng_start     <= 1'b0;
          state         <= ST_GAP;
        end
        ST_ABORT: begin
          res_n         <= job_n;
          res_factorial <= '0;
          res_error     <= 1'b1;
          eng_start     <= 1'b0;
          state         <= ST_GAP;
        end
        ST_GAP: begin
          res_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_factorial_job_sequencer
//   Directed bench for factorial_job_sequencer with a small behavioural
//   engine: output_ready rises a fixed number of cycles after start, and the
//   true factorial only appears on eng_factorial one cycle later.
// ---------------------------------------------------------------------------
module tb_factorial_job_sequencer;

  localparam int ENG_LAT = 3;

  logic        clk_32b = 1'b0;
  logic        resetn_32b = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_n = '0;
  logic        req_ready;
  logic [31:0] eng_source_number;
  logic        eng_start;
  logic [63:0] eng_factorial = 64'hDEAD_BEEF_0BAD_F00D;
  logic        eng_output_ready = 1'b0;
  logic        res_valid;
  logic [31:0] res_n;
  logic [63:0] res_factorial;
  logic        res_error;
  logic        res_ready = 1'b0;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          eng_cnt = 0;
  logic [31:0] eng_dead_n = 32'hFFFF_FFFF;
  logic        start_q = 1'b0;
  int          start_rises = 0;
  int          start_cycles = 0;

  factorial_job_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_32b           (clk_32b),
    .resetn_32b        (resetn_32b),
    .req_valid         (req_valid),
    .req_n             (req_n),
    .req_ready         (req_ready),
    .eng_source_number (eng_source_number),
    .eng_start         (eng_start),
    .eng_factorial     (eng_factorial),
    .eng_output_ready  (eng_output_ready),
    .res_valid         (res_valid),
    .res_n             (res_n),
    .res_factorial     (res_factorial),
    .res_error         (res_error),
    .res_ready         (res_ready),
    .busy              (busy)
  );

  always #5 clk_32b = ~clk_32b;

  function automatic logic [63:0] fact_ref(input logic [31:0] n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 64'(i);
    return r;
  endfunction

  // engine model: a job whose N equals eng_dead_n never completes
  always @(posedge clk_32b) begin
    if (!eng_start) begin
      eng_cnt          <= 0;
      eng_output_ready <= 1'b0;
      eng_factorial    <= 64'hDEAD_BEEF_0BAD_F00D;
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (eng_source_number != eng_dead_n && eng_cnt == ENG_LAT) eng_output_ready <= 1'b1;
      if (eng_output_ready) eng_factorial <= fact_ref(eng_source_number);
    end
  end

  always @(posedge clk_32b) begin
    start_q <= eng_start;
    if (eng_start && !start_q) start_rises <= start_rises + 1;
    if (eng_start) start_cycles <= start_cycles + 1;
  end

  task automatic push(input logic [31:0] n, output bit ok);
    int k;
    k = 0;
    req_valid = 1'b1;
    req_n = n;
    while (!req_ready && k < 200) begin
      @(negedge clk_32b);
      k++;
    end
    ok = req_ready;
    @(negedge clk_32b);
    req_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [31:0] n, output logic [63:0] f,
                            output logic e, output bit got, output bit stable);
    int k;
    k = 0;
    got = 0;
    stable = 1;
    n = '0;
    f = '0;
    e = 1'b0;
    while (!res_valid && k < 400) begin
      @(negedge clk_32b);
      k++;
    end
    if (res_valid) begin
      got = 1;
      n = res_n;
      f = res_factorial;
      e = res_error;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_32b);
        if (!res_valid || res_n !== n || res_factorial !== f || res_error !== e) stable = 0;
      end
      res_ready = 1'b1;
      @(negedge clk_32b);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_32b);
    @(negedge clk_32b);
    total++;
    if ({req_ready, eng_start, res_valid, res_error, busy} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000", {req_ready, eng_start, res_valid, res_error, busy});
    end
    total++;
    if (res_factorial !== 64'd0 || res_n !== 32'd0 || eng_source_number !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_data: got fact=%0d n=%0d src=%0d want 0/0/0", res_factorial, res_n, eng_source_number);
    end
    resetn_32b = 1'b1;
    @(negedge clk_32b);
    @(negedge clk_32b);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    int k;
    push(32'd5, ok);
    k = 0;
    while (!eng_start && k < 100) begin
      @(negedge clk_32b);
      k++;
    end
    total++;
    if (eng_start !== 1'b1 || eng_source_number !== 32'd5 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_start: got start=%b src=%0d busy=%b want 1/5/1", eng_start, eng_source_number, busy);
    end
    get_result(2, n, f, e, got, st);
    total++;
    if (!got || n !== 32'd5 || f !== 64'd120 || e !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_n5: got valid=%0d n=%0d fact=%0d err=%b want 5/120/0", got, n, f, e);
    end
    @(negedge clk_32b);
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_release: got res_valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    int rises0;
    logic [63:0] exp_f [3];
    exp_f[0] = 64'd1; exp_f[1] = 64'd1; exp_f[2] = 64'd2;
    rises0 = start_rises;
    for (int i = 0; i < 3; i++) push(32'(i), ok);
    for (int i = 0; i < 3; i++) begin
      get_result(0, n, f, e, got, st);
      total++;
      if (!got || n !== 32'(i) || f !== exp_f[i] || e !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bypass_n%0d: got valid=%0d n=%0d fact=%0d err=%b want %0d/%0d/0", i, got, n, f, e, i, exp_f[i]);
      end
    end
    total++;
    if (start_rises != rises0) begin
      bad++;
      $display("[TB] FAIL bypass_no_start: got %0d start pulses want 0", start_rises - rises0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    int rises0;
    logic [31:0] job [4];
    logic [63:0] exp_f [4];
    job[0] = 32'd3; job[1] = 32'd4; job[2] = 32'd6; job[3] = 32'd20;
    exp_f[0] = 64'd6; exp_f[1] = 64'd24; exp_f[2] = 64'd720; exp_f[3] = 64'd2432902008176640000;
    rises0 = start_rises;
    for (int i = 0; i < 4; i++) push(job[i], ok);
    for (int i = 0; i < 4; i++) begin
      get_result(10, n, f, e, got, st);
      total++;
      if (!got || n !== job[i] || f !== exp_f[i] || e !== 1'b0 || !st) begin
        bad++;
        $display("[TB] FAIL queue_job%0d: got valid=%0d n=%0d fact=%0d err=%b stable=%0d want %0d/%0d/0/1",
                 i, got, n, f, e, st, job[i], exp_f[i]);
      end
    end
    total++;
    if (start_rises - rises0 != 4) begin
      bad++;
      $display("[TB] FAIL queue_start_gaps: got %0d start pulses want 4", start_rises - rises0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    int cyc0;
    eng_dead_n = 32'd7;
    cyc0 = start_cycles;
    push(32'd7, ok);
    push(32'd4, ok);
    get_result(1, n, f, e, got, st);
    total++;
    if (!got || n !== 32'd7 || f !== 64'd0 || e !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_abort: got valid=%0d n=%0d fact=%0d err=%b want 7/0/1", got, n, f, e);
    end
    total++;
    if (start_cycles - cyc0 != 64) begin
      bad++;
      $display("[TB] FAIL timeout_run_cycles: got %0d want 64", start_cycles - cyc0);
    end
    get_result(0, n, f, e, got, st);
    total++;
    if (!got || n !== 32'd4 || f !== 64'd24 || e !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_next_job: got valid=%0d n=%0d fact=%0d err=%b want 4/24/0", got, n, f, e);
    end
    eng_dead_n = 32'hFFFF_FFFF;
  endtask

  task automatic test_overflow();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    logic [63:0] want_f;
    logic        want_e;
`ifdef FACT_SEQ_OVERFLOW_GUARD_EN
    want_f = 64'd0;
    want_e = 1'b1;
`else
    want_f = fact_ref(32'd21);
    want_e = 1'b0;
`endif
    push(32'd21, ok);
    get_result(0, n, f, e, got, st);
    total++;
    if (!got || n !== 32'd21 || f !== want_f || e !== want_e) begin
      bad++;
      $display("[TB] FAIL overflow_n21: got valid=%0d n=%0d fact=%0d err=%b want 21/%0d/%b", got, n, f, e, want_f, want_e);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    int k;
    logic [31:0] job [5];
    logic [63:0] exp_f [5];
    job[0] = 32'd2; job[1] = 32'd0; job[2] = 32'd5; job[3] = 32'd3; job[4] = 32'd4;
    exp_f[0] = 64'd2; exp_f[1] = 64'd1; exp_f[2] = 64'd120; exp_f[3] = 64'd6; exp_f[4] = 64'd24;
    // park a result so the FSM cannot pop while the queue fills
    push(32'd1, ok);
    k = 0;
    while (!res_valid && k < 50) begin
      @(negedge clk_32b);
      k++;
    end
    total++;
    if (res_valid !== 1'b1 || res_n !== 32'd1 || res_factorial !== 64'd1) begin
      bad++;
      $display("[TB] FAIL full_parked: got valid=%b n=%0d fact=%0d want 1/1/1", res_valid, res_n, res_factorial);
    end
    for (int i = 0; i < 4; i++) push(job[i], ok);
    req_valid = 1'b1;
    req_n = job[4];
    for (int i = 0; i < 3; i++) @(negedge clk_32b);
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_stall: got req_ready=%b want 0", req_ready);
    end
    res_ready = 1'b1;
    @(negedge clk_32b);
    res_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk_32b);
      k++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_accept_after_pop: got req_ready=%b want 1", req_ready);
    end
    @(negedge clk_32b);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      get_result(0, n, f, e, got, st);
      total++;
      if (!got || n !== job[i] || f !== exp_f[i] || e !== 1'b0) begin
        bad++;
        $display("[TB] FAIL full_drain%0d: got valid=%0d n=%0d fact=%0d err=%b want %0d/%0d/0", i, got, n, f, e, job[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] n; logic [63:0] f; logic e; bit got, st, ok;
    int k;
    eng_dead_n = 32'd9;
    push(32'd9, ok);
    push(32'd5, ok);
    k = 0;
    while (!eng_start && k < 50) begin
      @(negedge clk_32b);
      k++;
    end
    for (int i = 0; i < 5; i++) @(negedge clk_32b);
    total++;
    if (eng_start !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrun_started: got eng_start=%b want 1", eng_start);
    end
    resetn_32b = 1'b0;
    #1;
    total++;
    if ({eng_start, res_valid, busy, req_ready} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL midrun_async_clear: got start/valid/busy/ready=%b want 0000", {eng_start, res_valid, busy, req_ready});
    end
    @(negedge clk_32b);
    resetn_32b = 1'b1;
    eng_dead_n = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) @(negedge clk_32b);
    total++;
    if ({busy, eng_start, res_valid, req_ready} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL midrun_fifo_empty: got busy/start/valid/ready=%b want 0001", {busy, eng_start, res_valid, req_ready});
    end
    push(32'd6, ok);
    get_result(0, n, f, e, got, st);
    total++;
    if (!got || n !== 32'd6 || f !== 64'd720 || e !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrun_recover: got valid=%0d n=%0d fact=%0d err=%b want 6/720/0", got, n, f, e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bypass();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_fifo_full();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
